// File: rtl/gen_scheduler.sv
// gen_scheduler
//   Paces the life-field simulation. In run mode a new generation is started
//   every o_fpg vertical blanks; in pause mode a single generation can be
//   stepped at the next vertical blank. Configuration loads take priority over
//   new generations but never preempt one that is already in flight.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_frame_start         one-cycle pulse at the start of each vertical blank
//   i_cmd_toggle_pause    button pulse: flip run/pause mode
//   i_cmd_step            button pulse: request one generation while paused
//   i_cmd_speed_up/down   button pulses: fewer/more frames per generation
//   i_load_req            level: a configuration load is pending
//   i_nfi_busy            next-field iterator is simulating
//   i_fcl_busy            configuration loader is loading
//   o_nfi_go              request one generation (high only in GO)
//   o_fcl_grant           permission to load (high only in GRANT)
//   o_paused              1 = pause mode
//   o_fpg                 current frames per generation
//   o_gen_cnt             generations completed since the last load
module gen_scheduler #(
  parameter int FPG_MAX  = 60,
  parameter int FPG_INIT = 8,
  parameter int GEN_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_frame_start,
  input  logic                           i_cmd_toggle_pause,
  input  logic                           i_cmd_step,
  input  logic                           i_cmd_speed_up,
  input  logic                           i_cmd_speed_down,
  input  logic                           i_load_req,
  input  logic                           i_nfi_busy,
  input  logic                           i_fcl_busy,
  output logic                           o_nfi_go,
  output logic                           o_fcl_grant,
  output logic                           o_paused,
  output logic [$clog2(FPG_MAX+1)-1:0]   o_fpg,
  output logic [GEN_W-1:0]               o_gen_cnt
);

  localparam int FW = $clog2(FPG_MAX + 1);

  localparam logic [FW-1:0]    FPG_ONE    = FW'(32'd1);
  localparam logic [FW-1:0]    FPG_MAX_V  = FW'(FPG_MAX);
  localparam logic [FW-1:0]    FPG_INIT_V = FW'(FPG_INIT);
  localparam logic [GEN_W-1:0] GEN_ONE    = GEN_W'(32'd1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GO    = 3'd1,
    SIM   = 3'd2,
    GRANT = 3'd3,
    LOAD  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [FW-1:0]     frame_cnt_r;
  logic [FW-1:0]     frame_cnt_s;
  logic              step_r;
  logic              step_s;
  logic              step_req_s;
  logic [FW:0]       frame_inc_s;
  logic              paused_s;
  logic [FW-1:0]     fpg_s;
  logic [GEN_W-1:0]  gen_cnt_s;

  // Frames-per-generation update; opposing commands in one cycle cancel out.
  always_comb begin
    fpg_s = o_fpg;
    if (i_cmd_speed_up && !i_cmd_speed_down) begin
      if (o_fpg > FPG_ONE) begin
        fpg_s = o_fpg - FPG_ONE;
      end else begin
        fpg_s = o_fpg;
      end
    end else if (i_cmd_speed_down && !i_cmd_speed_up) begin
      if (o_fpg < FPG_MAX_V) begin
        fpg_s = o_fpg + FPG_ONE;
      end else begin
        fpg_s = o_fpg;
      end
    end else begin
      fpg_s = o_fpg;
    end
  end

  // Next-state logic for the scheduler FSM and its counters.
  always_comb begin
    state_s     = state_r;
    frame_cnt_s = frame_cnt_r;
    gen_cnt_s   = o_gen_cnt;
    paused_s    = o_paused ^ i_cmd_toggle_pause;
    // A step that coincides with a pause toggle is dropped.
    step_req_s  = i_cmd_step & ~i_cmd_toggle_pause;
    frame_inc_s = {1'b0, frame_cnt_r} + {{FW{1'b0}}, 1'b1};

    // Steps are only remembered while paused; in run mode they are ignored.
    if (!o_paused) begin
      step_s = 1'b0;
    end else if (step_req_s) begin
      step_s = 1'b1;
    end else begin
      step_s = step_r;
    end

    case (state_r)
      IDLE: begin
        if (i_load_req) begin
          state_s = GRANT;
        end else if (!o_paused) begin
          // Compare with >= so that shrinking o_fpg below the running count
          // fires on the very next vertical blank.
          if (i_frame_start) begin
            if (frame_inc_s >= {1'b0, o_fpg}) begin
              frame_cnt_s = {FW{1'b0}};
              state_s     = GO;
            end else begin
              frame_cnt_s = frame_inc_s[FW-1:0];
            end
          end else begin
            frame_cnt_s = frame_cnt_r;
          end
        end else begin
          if (i_frame_start && (step_r || step_req_s)) begin
            step_s  = 1'b0;
            state_s = GO;
          end else begin
            state_s = IDLE;
          end
        end
      end
      GO: begin
        if (i_nfi_busy) begin
          state_s = SIM;
        end else begin
          state_s = GO;
        end
      end
      SIM: begin
        if (!i_nfi_busy) begin
          gen_cnt_s = o_gen_cnt + GEN_ONE;
          state_s   = IDLE;
        end else begin
          state_s = SIM;
        end
      end
      GRANT: begin
        if (i_fcl_busy) begin
          state_s = LOAD;
        end else begin
          state_s = GRANT;
        end
      end
      LOAD: begin
        if (!i_fcl_busy) begin
          gen_cnt_s   = {GEN_W{1'b0}};
          frame_cnt_s = {FW{1'b0}};
          step_s      = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = LOAD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; handshake outputs are decoded from the next
  // state so they are registered yet high exactly while in GO / GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      o_nfi_go    <= 1'b0;
      o_fcl_grant <= 1'b0;
      o_paused    <= 1'b1;
      o_fpg       <= FPG_INIT_V;
      o_gen_cnt   <= {GEN_W{1'b0}};
      frame_cnt_r <= {FW{1'b0}};
      step_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      o_nfi_go    <= (state_s == GO);
      o_fcl_grant <= (state_s == GRANT);
      o_paused    <= paused_s;
      o_fpg       <= fpg_s;
      o_gen_cnt   <= gen_cnt_s;
      frame_cnt_r <= frame_cnt_s;
      step_r      <= step_s;
    end
  end

endmodule

// File: tb/tb_gen_scheduler.sv
// tb_gen_scheduler
//   Self-checking bench for gen_scheduler. Speed/pause commands are applied
//   from a vector table; generation, load, step and reset scenarios are
//   hand-written sequences. Expected generation counts are pushed to a
//   scoreboard queue when a generation is triggered and popped when the
//   iterator handshake completes. GEN_W is reduced to 8 so wrap-around can be
//   reached quickly.
module tb_gen_scheduler;

  localparam int FPG_MAX  = 60;
  localparam int FPG_INIT = 8;
  localparam int GEN_W    = 8;
  localparam int FW       = $clog2(FPG_MAX + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_frame_start = 1'b0;
  logic             i_cmd_toggle_pause = 1'b0;
  logic             i_cmd_step = 1'b0;
  logic             i_cmd_speed_up = 1'b0;
  logic             i_cmd_speed_down = 1'b0;
  logic             i_load_req = 1'b0;
  logic             i_nfi_busy = 1'b0;
  logic             i_fcl_busy = 1'b0;
  logic             o_nfi_go;
  logic             o_fcl_grant;
  logic             o_paused;
  logic [FW-1:0]    o_fpg;
  logic [GEN_W-1:0] o_gen_cnt;

  int errors = 0;
  int checks = 0;
  int model_gen = 0;
  int gen_q[$];
  int cfg_q[$];

  typedef struct {
    logic up;
    logic down;
    logic tog;
    int   reps;
    int   exp_fpg;
    int   exp_paused;
  } vec_t;

  vec_t vecs[8];

  gen_scheduler #(
    .FPG_MAX (FPG_MAX),
    .FPG_INIT(FPG_INIT),
    .GEN_W   (GEN_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_frame_start     (i_frame_start),
    .i_cmd_toggle_pause(i_cmd_toggle_pause),
    .i_cmd_step        (i_cmd_step),
    .i_cmd_speed_up    (i_cmd_speed_up),
    .i_cmd_speed_down  (i_cmd_speed_down),
    .i_load_req        (i_load_req),
    .i_nfi_busy        (i_nfi_busy),
    .i_fcl_busy        (i_fcl_busy),
    .o_nfi_go          (o_nfi_go),
    .o_fcl_grant       (o_fcl_grant),
    .o_paused          (o_paused),
    .o_fpg             (o_fpg),
    .o_gen_cnt         (o_gen_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled there as well.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_frame();
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    tick();
  endtask

  task automatic pulse_toggle();
    i_cmd_toggle_pause = 1'b1;
    tick();
    i_cmd_toggle_pause = 1'b0;
  endtask

  task automatic push_gen();
    model_gen = (model_gen + 1) % (1 << GEN_W);
    gen_q.push_back(model_gen);
  endtask

  task automatic pop_gen(input string name);
    if (gen_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      check(name, int'(o_gen_cnt), gen_q.pop_front());
    end
  endtask

  // Iterator model: busy rises 2 cycles after go, stays for busy_len cycles.
  task automatic run_gen(input int busy_len);
    int n;
    n = 0;
    while (!o_nfi_go && n < 50) begin
      tick();
      n++;
    end
    check("go_seen", int'(o_nfi_go), 1);
    if (o_nfi_go) begin
      tick();
      tick();
      check("go_hold", int'(o_nfi_go), 1);
      i_nfi_busy = 1'b1;
      tick();
      check("go_drop", int'(o_nfi_go), 0);
      repeat (busy_len - 1) tick();
      i_nfi_busy = 1'b0;
      tick();
      pop_gen("gen_cnt");
      check("go_idle", int'(o_nfi_go), 0);
    end else if (gen_q.size() > 0) begin
      void'(gen_q.pop_front());
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 10, 1,  1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 70, 60, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1,  60, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1,  59, 1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1,  59, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1,  59, 1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1,  60, 1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 52, 8,  1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_go", int'(o_nfi_go), 0);
    check("rst_grant", int'(o_fcl_grant), 0);
    check("rst_paused", int'(o_paused), 1);
    check("rst_fpg", int'(o_fpg), FPG_INIT);
    check("rst_gen", int'(o_gen_cnt), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_paused", int'(o_paused), 1);

    // Speed and pause command table
    for (int v = 0; v < 8; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        i_cmd_speed_up     = vecs[v].up;
        i_cmd_speed_down   = vecs[v].down;
        i_cmd_toggle_pause = vecs[v].tog;
        if (r == vecs[v].reps - 1) begin
          cfg_q.push_back(vecs[v].exp_fpg);
          cfg_q.push_back(vecs[v].exp_paused);
        end
        tick();
      end
      i_cmd_speed_up     = 1'b0;
      i_cmd_speed_down   = 1'b0;
      i_cmd_toggle_pause = 1'b0;
      check("vec_fpg", int'(o_fpg), cfg_q.pop_front());
      check("vec_paused", int'(o_paused), cfg_q.pop_front());
    end

    // Run mode: go after the 8th frame start
    pulse_toggle();
    check("run_paused", int'(o_paused), 0);
    for (int f = 0; f < 7; f++) begin
      pulse_frame();
      check("run_no_go", int'(o_nfi_go), 0);
    end
    push_gen();
    pulse_frame();
    check("run_go_8th", int'(o_nfi_go), 1);
    run_gen(10);

    // Load requested during SIM waits for the generation to finish
    for (int f = 0; f < 7; f++) pulse_frame();
    push_gen();
    pulse_frame();
    check("ld_go", int'(o_nfi_go), 1);
    i_nfi_busy = 1'b1;
    tick();
    pulse_frame();
    i_load_req = 1'b1;
    tick();
    tick();
    check("ld_grant_wait", int'(o_fcl_grant), 0);
    i_nfi_busy = 1'b0;
    tick();
    pop_gen("ld_gen_cnt");
    check("ld_grant_sim_end", int'(o_fcl_grant), 0);
    tick();
    check("ld_grant", int'(o_fcl_grant), 1);
    i_load_req = 1'b0;
    tick();
    check("ld_grant_hold", int'(o_fcl_grant), 1);
    i_fcl_busy = 1'b1;
    tick();
    check("ld_grant_drop", int'(o_fcl_grant), 0);
    repeat (3) tick();
    i_fcl_busy = 1'b0;
    tick();
    model_gen = 0;
    check("ld_gen_clear", int'(o_gen_cnt), 0);
    check("ld_no_go", int'(o_nfi_go), 0);

    // Shrinking o_fpg below frame_cnt fires on the next frame start
    for (int f = 0; f < 5; f++) begin
      pulse_frame();
      check("shr_no_go", int'(o_nfi_go), 0);
    end
    i_cmd_speed_up = 1'b1;
    repeat (3) tick();
    i_cmd_speed_up = 1'b0;
    check("shr_fpg", int'(o_fpg), 5);
    push_gen();
    pulse_frame();
    check("shr_go", int'(o_nfi_go), 1);
    run_gen(2);
    i_cmd_speed_down = 1'b1;
    repeat (3) tick();
    i_cmd_speed_down = 1'b0;
    check("shr_fpg_back", int'(o_fpg), 8);

    // Pause; single step then three frame starts
    pulse_toggle();
    check("step_paused", int'(o_paused), 1);
    i_cmd_step = 1'b1;
    tick();
    i_cmd_step = 1'b0;
    tick();
    check("step_latched_no_go", int'(o_nfi_go), 0);
    push_gen();
    pulse_frame();
    check("step_go", int'(o_nfi_go), 1);
    run_gen(3);
    for (int f = 0; f < 2; f++) begin
      pulse_frame();
      check("step_no_more_go", int'(o_nfi_go), 0);
    end
    check("step_gen_cnt", int'(o_gen_cnt), model_gen);

    // Toggle together with step: step dropped
    i_cmd_toggle_pause = 1'b1;
    i_cmd_step         = 1'b1;
    tick();
    i_cmd_toggle_pause = 1'b0;
    i_cmd_step         = 1'b0;
    check("ts_running", int'(o_paused), 0);
    pulse_toggle();
    check("ts_paused", int'(o_paused), 1);
    pulse_frame();
    check("ts_no_go", int'(o_nfi_go), 0);

    // Step up to the top of the counter, then wrap
    while (model_gen != (1 << GEN_W) - 1) begin
      i_cmd_step    = 1'b1;
      i_frame_start = 1'b1;
      push_gen();
      tick();
      i_cmd_step    = 1'b0;
      i_frame_start = 1'b0;
      run_gen(1);
    end
    check("gen_max", int'(o_gen_cnt), (1 << GEN_W) - 1);
    i_cmd_step    = 1'b1;
    i_frame_start = 1'b1;
    push_gen();
    tick();
    i_cmd_step    = 1'b0;
    i_frame_start = 1'b0;
    run_gen(1);
    check("gen_wrap", int'(o_gen_cnt), 0);

    // Reset in the middle of GO
    i_cmd_speed_down = 1'b1;
    tick();
    i_cmd_speed_down = 1'b0;
    check("rg_fpg9", int'(o_fpg), 9);
    i_cmd_step    = 1'b1;
    i_frame_start = 1'b1;
    tick();
    i_cmd_step    = 1'b0;
    i_frame_start = 1'b0;
    check("rg_go", int'(o_nfi_go), 1);
    i_nfi_busy = 1'b1;
    rst_n      = 1'b0;
    #1;
    check("rg_go_async", int'(o_nfi_go), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rg_go_after", int'(o_nfi_go), 0);
    check("rg_paused", int'(o_paused), 1);
    check("rg_fpg", int'(o_fpg), FPG_INIT);
    check("rg_gen", int'(o_gen_cnt), 0);
    i_nfi_busy = 1'b0;
    model_gen  = 0;
    gen_q.delete();
    i_cmd_step    = 1'b1;
    i_frame_start = 1'b1;
    push_gen();
    tick();
    i_cmd_step    = 1'b0;
    i_frame_start = 1'b0;
    run_gen(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
